port_arbiter: RTL and testbench

Per-output-port scheduler for the 4-port switch. Watches the head-of-line target header of every input FIFO and picks, round-robin, one FIFO whose head packet targets this output. It pulses that FIFO's rd_en, captures the registered FIFO data_out, and presents the packet on a valid/ready output interface. One instance sits per output port, between the input FIFOs and the output driver.

---
 rtl/port_arbiter.sv | 140 ++++++++++++++
 tb/tb_port_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/port_arbiter.sv
// Per-output-port scheduler: round-robin pick of an input FIFO whose head targets PORT_ID, pop it, present packet.
// Latency: request seen in IDLE at cycle N -> rd_en at N+1 -> out_valid from N+3; 4 cycles minimum per packet.
// Backpressure: out_ready low holds the packet in SEND indefinitely; no FIFO is read until it is accepted.
module port_arbiter #(
  parameter int PKT_SIZE  = 16,
  parameter int NUM_PORTS = 4,
  parameter int PORT_ID   = 0,
  localparam int HDR_W    = PKT_SIZE >> 2,
  localparam int IDX_W    = $clog2(NUM_PORTS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PORTS-1:0]          fifo_empty,
  input  logic [NUM_PORTS*HDR_W-1:0]    fifo_header,
  input  logic [NUM_PORTS*PKT_SIZE-1:0] fifo_data,
  output logic [NUM_PORTS-1:0]          rd_en,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [PKT_SIZE-1:0]           out_data,
  output logic [IDX_W-1:0]              grant_id,
  output logic                          busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_LOAD = 2'd2,
    S_SEND = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      grant_id_q, grant_id_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [PKT_SIZE-1:0]   out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;

  logic [NUM_PORTS-1:0]  req;
  logic                  any_req;
  logic [IDX_W-1:0]      winner;
  logic [PKT_SIZE-1:0]   sel_data;

  // A FIFO requests only when it holds a packet whose target field is this port.
  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      req[i] = !fifo_empty[i] && (fifo_header[i*HDR_W +: HDR_W] == HDR_W'(PORT_ID));
    end
  end

  // Round-robin scan starting at rr_ptr; descending loop so the smallest offset wins.
  always_comb begin
    logic [IDX_W-1:0] idx;
    any_req = 1'b0;
    winner  = '0;
    idx     = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      idx = rr_ptr_q + IDX_W'(k);
      if (req[idx]) begin
        any_req = 1'b1;
        winner  = idx;
      end
    end
  end

  // Mux the registered data_out of the granted FIFO.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_id_q == IDX_W'(i)) begin
        sel_data = fifo_data[i*PKT_SIZE +: PKT_SIZE];
      end
    end
  end

  // Next-state logic; requests are only sampled in IDLE so pop side effects cannot re-trigger a read.
  always_comb begin
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    rr_ptr_d    = rr_ptr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          grant_id_d = winner;
          rr_ptr_d   = winner + IDX_W'(1);
          state_d    = S_READ;
        end
      end
      S_READ: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        out_data_d  = sel_data;
        out_valid_d = 1'b1;
        state_d     = S_SEND;
      end
      S_SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any in-flight packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      grant_id_q  <= '0;
      rr_ptr_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_id_q  <= grant_id_d;
      rr_ptr_q    <= rr_ptr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Read strobe decoded from registered state: one-hot, only during READ.
  always_comb begin
    rd_en = '0;
    if (state_q == S_READ) begin
      rd_en[grant_id_q] = 1'b1;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign grant_id  = grant_id_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_port_arbiter.sv
// Bench for port_arbiter (PORT_ID=2): behavioural FIFO model plus transaction-level arbiter reference.
// Checks every cycle against the reference, plus directed scenario checks and a randomized phase.
// Drives out_ready directly to exercise backpressure.
module tb_port_arbiter;
  localparam int NP = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  fifo_empty;
  logic [15:0] fifo_header;
  logic [63:0] fifo_data;
  logic [3:0]  rd_en;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [1:0]  grant_id;
  logic        busy;

  always #5 clk = ~clk;

  port_arbiter #(.PKT_SIZE(16), .NUM_PORTS(4), .PORT_ID(2)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_header(fifo_header),
    .fifo_data(fifo_data), .rd_en(rd_en), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .grant_id(grant_id), .busy(busy)
  );

  // Input FIFO model
  logic [15:0] fq [NP][$];
  logic [3:0]  stale [NP];
  logic [15:0] dout [NP];

  // Reference arbiter: m_age counts cycles since grant (1 = read strobe, >=3 = packet offered)
  bit          m_active;
  int          m_age, m_gid, m_ptr;
  logic [15:0] m_pkt, m_out;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int gobs[$];
  int gcyc[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifos();
    for (int i = 0; i < NP; i++) begin
      fifo_empty[i]          = (fq[i].size() == 0);
      fifo_header[i*4 +: 4]  = (fq[i].size() > 0) ? fq[i][0][11:8] : stale[i];
      fifo_data[i*16 +: 16]  = dout[i];
    end
  endtask

  task automatic push(input int i, input logic [15:0] p);
    fq[i].push_back(p);
    drive_fifos();
  endtask

  task automatic model_reset();
    m_active = 0; m_age = 0; m_gid = 0; m_ptr = 0; m_pkt = '0; m_out = '0;
  endtask

  task automatic compare_model();
    logic [3:0] e_rd;
    e_rd = '0;
    if (m_active && m_age == 1) e_rd[m_gid] = 1'b1;
    check("rd_en", 32'(rd_en), 32'(e_rd));
    check("out_valid", 32'(out_valid), 32'(m_active && m_age >= 3));
    check("out_data", 32'(out_data), 32'(m_out));
    check("grant_id", 32'(grant_id), 32'(m_gid));
    check("busy", 32'(busy), 32'(m_active));
  endtask

  // One clock: snapshot pre-edge inputs at negedge, then update FIFOs and model after the edge.
  task automatic step();
    logic [3:0]  s_req, s_rd;
    logic        s_ready;
    logic [15:0] s_head [NP];
    int          w;
    @(negedge clk);
    s_rd    = rd_en;
    s_ready = out_ready;
    for (int i = 0; i < NP; i++) begin
      s_req[i]  = (fq[i].size() > 0) && (fq[i][0][11:8] == 4'd2);
      s_head[i] = (fq[i].size() > 0) ? fq[i][0] : 16'h0;
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NP; i++) begin
      if (s_rd[i]) begin
        check("pop_nonempty", 32'(fq[i].size() > 0), 32'd1);
        if (fq[i].size() > 0) begin
          dout[i]  = fq[i].pop_front();
          stale[i] = dout[i][11:8];
        end
        gobs.push_back(i);
        gcyc.push_back(cyc);
      end
    end
    drive_fifos();
    if (rst_n) begin
      if (!m_active) begin
        if (s_req != 4'd0) begin
          w = -1;
          for (int k = 0; k < NP; k++) begin
            if (w < 0 && s_req[(m_ptr + k) % NP]) w = (m_ptr + k) % NP;
          end
          m_active = 1; m_age = 1; m_gid = w; m_ptr = (w + 1) % NP; m_pkt = s_head[w];
        end
      end else if (m_age < 3) begin
        m_age++;
        if (m_age == 3) m_out = m_pkt;
      end else if (s_ready) begin
        m_active = 0;
      end
    end
    compare_model();
  endtask

  // Asynchronous reset in the middle of a cycle, checked before any clock edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    gobs.delete();
    gcyc.delete();
  endtask

  initial begin
    int exp2[5];
    int exp3[5];
    int exp6[3];
    logic [3:0]  tg;
    logic [15:0] pk;
    int f;

    rst_n = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < NP; i++) begin
      stale[i] = 4'd0;
      dout[i]  = 16'h0;
    end
    drive_fifos();
    model_reset();
    #1;
    check("init_busy", 32'(busy), 32'd0);
    check("init_rd_en", 32'(rd_en), 32'd0);
    step();
    step();
    rst_n = 1'b1;

    // 1: single packet on FIFO1
    push(1, 16'h12A5);
    step();
    check("t1_rd_en", 32'(rd_en), 32'h2);
    step();
    check("t1_load_rd_en", 32'(rd_en), 32'h0);
    check("t1_load_valid", 32'(out_valid), 32'h0);
    step();
    check("t1_valid", 32'(out_valid), 32'h1);
    check("t1_data", 32'(out_data), 32'h12A5);
    check("t1_gid", 32'(grant_id), 32'h1);
    step();
    check("t1_idle", 32'(busy), 32'h0);
    check("t1_npulse", 32'(gobs.size()), 32'd1);

    // 2: all four FIFOs request, round-robin from 0, refill FIFO0
    do_reset();
    for (int i = 0; i < NP; i++) push(i, {4'(i), 4'd2, 8'(8'h30 + i)});
    repeat (16) step();
    push(0, 16'h52EE);
    repeat (6) step();
    exp2 = '{0, 1, 2, 3, 0};
    check("t2_ngrants", 32'(gobs.size()), 32'd5);
    for (int k = 0; k < 5 && k < gobs.size(); k++) check("t2_order", 32'(gobs[k]), 32'(exp2[k]));
    for (int k = 0; k < 3 && k + 1 < gcyc.size(); k++) check("t2_spacing", 32'(gcyc[k+1] - gcyc[k]), 32'd4);

    // 3: wrap from rr_ptr=3
    do_reset();
    push(2, 16'h22C0);
    repeat (5) step();
    push(0, 16'h02C1);
    push(3, 16'h32C2);
    repeat (8) step();
    push(0, 16'h02C3);
    push(1, 16'h12C4);
    repeat (9) step();
    exp3 = '{2, 3, 0, 1, 0};
    check("t3_ngrants", 32'(gobs.size()), 32'd5);
    for (int k = 0; k < 5 && k < gobs.size(); k++) check("t3_order", 32'(gobs[k]), 32'(exp3[k]));

    // 4: backpressure in SEND
    do_reset();
    out_ready = 1'b0;
    push(2, 16'h42C3);
    step();
    push(0, 16'h0255);
    step();
    step();
    for (int k = 0; k < 10; k++) begin
      step();
      check("t4_valid", 32'(out_valid), 32'd1);
      check("t4_data", 32'(out_data), 32'h42C3);
      check("t4_no_rd", 32'(rd_en), 32'd0);
      check("t4_busy", 32'(busy), 32'd1);
    end
    out_ready = 1'b1;
    step();
    check("t4_release_busy", 32'(busy), 32'd0);
    check("t4_release_valid", 32'(out_valid), 32'd0);
    repeat (5) step();
    check("t4_ngrants", 32'(gobs.size()), 32'd2);

    // 5: header mismatch and empty FIFO with stale matching header
    do_reset();
    push(0, 16'h3155);
    stale[1] = 4'd2;
    drive_fifos();
    for (int k = 0; k < 10; k++) begin
      step();
      check("t5_no_rd", 32'(rd_en), 32'd0);
      check("t5_busy", 32'(busy), 32'd0);
    end
    fq[0].delete();
    drive_fifos();

    // 6: reset during READ, then re-arbitrate from rr_ptr=0
    push(3, 16'h0287);
    repeat (4) step();
    push(3, 16'h0288);
    push(1, 16'h12AB);
    step();
    check("t6_read", 32'(rd_en), 32'h2);
    do_reset();
    repeat (10) step();
    exp6 = '{1, 3, 0};
    check("t6_ngrants", 32'(gobs.size()), 32'd2);
    for (int k = 0; k < 2 && k < gobs.size(); k++) check("t6_order", 32'(gobs[k]), 32'(exp6[k]));

    // Randomized traffic with random backpressure; foreign-target heads drained by other ports.
    for (int c = 0; c < 600; c++) begin
      out_ready = ($urandom_range(3) != 0);
      if ($urandom_range(2) == 0) begin
        f  = $urandom_range(3);
        tg = ($urandom_range(2) == 0) ? 4'($urandom_range(15)) : 4'd2;
        pk = {4'($urandom_range(15)), tg, 8'($urandom_range(255))};
        if (fq[f].size() < 4) fq[f].push_back(pk);
      end
      for (int i = 0; i < NP; i++) begin
        if (fq[i].size() > 0 && fq[i][0][11:8] != 4'd2 && $urandom_range(3) == 0) begin
          stale[i] = fq[i][0][11:8];
          void'(fq[i].pop_front());
        end
      end
      drive_fifos();
      step();
    end
    out_ready = 1'b1;
    repeat (6) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
